// File: rtl/w_mem_pkg.sv
// ---------------------------------------------------------------------------
// w_mem_pkg -- shared constants and types for the SHA-256 message schedule.
//
// Contents:
//   WORD_W / DEPTH / IDX_W     word width, window depth, schedule index width
//   S0_* / S1_*                rotate and shift amounts of sigma0 / sigma1
//   word_t                     one 32-bit schedule word
//   sigma_sel_e                selects which small-sigma a w_sigma computes
//   rotr()                     32-bit rotate right
// ---------------------------------------------------------------------------
package w_mem_pkg;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 6;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR   = 3;

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR   = 10;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        SIGMA0 = 1'b0,
        SIGMA1 = 1'b1
    } sigma_sel_e;

    // Amounts are always in 1..31, so neither shift degenerates.
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage : w_mem_pkg

// File: rtl/w_mem_if.sv
// ---------------------------------------------------------------------------
// w_mem_if -- schedule-word port bundle of w_mem.
//
// Signals:
//   I      schedule index t (0..63), driven by the sequencer
//   D_IN   message word W[t], meaningful only while I < 16
//   D_OUT  schedule word W[t], combinational from I, D_IN and the window
//
// Modports:
//   master  the sequencer / hash core that steps I and consumes D_OUT
//   slave   the w_mem block itself
// ---------------------------------------------------------------------------
interface w_mem_if;
    import w_mem_pkg::*;

    logic [IDX_W-1:0] I;
    word_t            D_IN;
    word_t            D_OUT;

    modport master (
        output I,
        output D_IN,
        input  D_OUT
    );

    modport slave (
        input  I,
        input  D_IN,
        output D_OUT
    );

endinterface : w_mem_if

// File: rtl/w_sigma.sv
// ---------------------------------------------------------------------------
// w_sigma -- SHA-256 small sigma function, purely combinational.
//
// Parameter:
//   SEL  SIGMA0 -> ROTR7 ^ ROTR18 ^ SHR3
//        SIGMA1 -> ROTR17 ^ ROTR19 ^ SHR10
// Ports:
//   x    32-bit input word
//   y    32-bit sigma(x)
// ---------------------------------------------------------------------------
module w_sigma
    import w_mem_pkg::*;
#(
    parameter sigma_sel_e SEL = SIGMA0
) (
    input  word_t x,
    output word_t y
);

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path through the block can leave it unassigned (no latch).
        y = '0;
        unique case (SEL)
            SIGMA0: y = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
            SIGMA1: y = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
            default: y = '0;
        endcase
    end

endmodule : w_sigma

// File: rtl/w_mem.sv
// ---------------------------------------------------------------------------
// w_mem -- SHA-256 message schedule generator with a 16-word sliding window.
//
// Ports:
//   CLK   sole clock, rising edge
//   RST   synchronous, active-high; clears the window
//   bus   w_mem_if.slave: I (index t), D_IN (W[t] for t < 16), D_OUT (W[t])
//
// Operation:
//   The window w0..w15 holds W[t-16]..W[t-1]. For t < 16 the message word
//   passes straight through; for t >= 16 D_OUT is
//   sigma1(w14) + w9 + sigma0(w1) + w0 (mod 2^32). Every cycle the window
//   shifts down one word and D_OUT enters at w15, so the sequencer must
//   advance I by one per cycle. There is no enable and no wrap handling:
//   after 63 the next 16 pass-through words simply refill the window.
// ---------------------------------------------------------------------------
module w_mem
    import w_mem_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    w_mem_if.slave   bus
);

    // Window words are kept as individual registers so each one can be
    // probed by name from a debugger or bench.
    word_t w0,  w1,  w2,  w3,  w4,  w5,  w6,  w7;
    word_t w8,  w9,  w10, w11, w12, w13, w14, w15;

    word_t s0;
    word_t s1;
    word_t d_out;

    w_sigma #(.SEL(SIGMA0)) u_sigma0 (.x(w1),  .y(s0));
    w_sigma #(.SEL(SIGMA1)) u_sigma1 (.x(w14), .y(s1));

    // Four-operand sum; the carry out of bit 31 is dropped by the word width.
    always_comb begin
        d_out = bus.D_IN;
        if (bus.I >= IDX_W'(DEPTH)) begin
            d_out = s1 + w9 + s0 + w0;
        end
    end

    assign bus.D_OUT = d_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the window is a handful of flops, not a RAM, so clearing
            // it on reset is cheap and gives a defined D_OUT during reset.
            w0  <= '0;  w1  <= '0;  w2  <= '0;  w3  <= '0;
            w4  <= '0;  w5  <= '0;  w6  <= '0;  w7  <= '0;
            w8  <= '0;  w9  <= '0;  w10 <= '0;  w11 <= '0;
            w12 <= '0;  w13 <= '0;  w14 <= '0;  w15 <= '0;
        end else begin
            // NOTE: non-blocking assignments make every word read its
            // neighbour's pre-edge value, which is what makes this a shift.
            w0  <= w1;   w1  <= w2;   w2  <= w3;   w3  <= w4;
            w4  <= w5;   w5  <= w6;   w6  <= w7;   w7  <= w8;
            w8  <= w9;   w9  <= w10;  w10 <= w11;  w11 <= w12;
            w12 <= w13;  w13 <= w14;  w14 <= w15;  w15 <= d_out;
        end
    end

endmodule : w_mem

// File: tb/tb_w_mem.sv
// ---------------------------------------------------------------------------
// tb_w_mem -- self-checking bench for w_mem.
//
// The stimulus process drives I / D_IN just after each rising edge and
// queues the values it expects for that cycle; a monitor drains the queue
// on the falling edge, comparing D_OUT or a named window word. Expected
// schedules come from a conventional array-based SHA-256 schedule model,
// alongside hand-computed constants.
// ---------------------------------------------------------------------------
module tb_w_mem;
    import w_mem_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    w_mem_if bus ();

    w_mem dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    typedef struct {
        string name;
        bit    is_win;   // 1: compare window word idx, 0: compare D_OUT
        int    idx;
        word_t exp;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    word_t msg   [16];
    word_t ref_w [64];

    function automatic word_t probe(input int k);
        case (k)
            0:  return dut.w0;   1:  return dut.w1;   2:  return dut.w2;   3:  return dut.w3;
            4:  return dut.w4;   5:  return dut.w5;   6:  return dut.w6;   7:  return dut.w7;
            8:  return dut.w8;   9:  return dut.w9;   10: return dut.w10;  11: return dut.w11;
            12: return dut.w12;  13: return dut.w13;  14: return dut.w14;  15: return dut.w15;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_out(input string nm, input word_t e);
        sb_t s;
        s.name = nm; s.is_win = 1'b0; s.idx = 0; s.exp = e;
        sb.push_back(s);
    endtask

    task automatic expect_win(input string nm, input int k, input word_t e);
        sb_t s;
        s.name = nm; s.is_win = 1'b1; s.idx = k; s.exp = e;
        sb.push_back(s);
    endtask

    // Monitor: everything queued during this cycle is checked mid-cycle.
    always @(negedge CLK) begin
        sb_t   s;
        word_t act;
        while (sb.size() > 0) begin
            s   = sb.pop_front();
            act = s.is_win ? probe(s.idx) : bus.D_OUT;
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL %s: got %08h, expected %08h", s.name, act, s.exp);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic word_t ror(input word_t x, input int n);
        word_t r;
        r = x;
        for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic word_t ssig0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ {3'b0, x[31:3]};
    endfunction

    function automatic word_t ssig1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ {10'b0, x[31:10]};
    endfunction

    task automatic build_ref();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = msg[t];
            else        ref_w[t] = ssig1(ref_w[t-2]) + ref_w[t-7] + ssig0(ref_w[t-15]) + ref_w[t-16];
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input int t, input word_t d);
        @(posedge CLK);
        #1;
        RST      = r;
        bus.I    = 6'(t);
        bus.D_IN = d;
    endtask

    function automatic word_t junk(input int t);
        return 32'hA5A5_5A5A ^ word_t'(t * 32'h0101_0101);
    endfunction

    initial begin
        bus.I    = '0;
        bus.D_IN = '0;

        // Reset with I = 16: window cleared, D_OUT = 0 even while RST is high.
        step(1'b1, 16, 32'h1234_5678);
        step(1'b1, 16, 32'h1234_5678);
        expect_out("reset_dout", 32'h0);
        for (int k = 0; k < 16; k++) expect_win($sformatf("reset_w%0d", k), k, 32'h0);

        // "Hello world!" padded block: full 64-word schedule.
        foreach (msg[k]) msg[k] = 32'h0;
        msg[0] = 32'h4865_6C6C; msg[1] = 32'h6F20_776F;
        msg[2] = 32'h726C_6421; msg[3] = 32'h8000_0000;
        msg[15] = 32'h0000_0060;
        build_ref();
        for (int t = 0; t < 64; t++) begin
            step(1'b0, t, (t < 16) ? msg[t] : junk(t));
            expect_out($sformatf("hello_W%0d", t), ref_w[t]);
            if (t == 0)  expect_out("pass_through_W0", 32'h4865_6C6C);
            if (t == 1)  expect_win("shift_in_w15", 15, 32'h4865_6C6C);
            if (t == 16) begin
                expect_out("hello_W16_const", 32'h1747_0237);
                expect_win("full_w0", 0, 32'h4865_6C6C);
                expect_win("full_w1", 1, 32'h6F20_776F);
                expect_win("full_w15", 15, 32'h0000_0060);
            end
        end

        // Wrap 63 -> 0: straight back to pass-through.
        step(1'b0, 0, 32'hDEAD_BEEF);
        expect_out("wrap_passthru", 32'hDEAD_BEEF);

        // One-cycle reset after a full run, then hold I = 16.
        step(1'b1, 16, 32'h0);
        step(1'b0, 16, 32'hFFFF_FFFF);
        expect_out("post_reset_dout", 32'h0);
        for (int k = 0; k < 16; k++) expect_win($sformatf("post_reset_w%0d", k), k, 32'h0);
        step(1'b0, 16, 32'hFFFF_FFFF);
        expect_out("post_reset_hold", 32'h0);

        // All-zero message: every expanded word is zero despite junk on D_IN.
        for (int t = 0; t < 64; t++) begin
            step(1'b0, t, (t < 16) ? 32'h0 : junk(t));
            if (t >= 16) expect_out($sformatf("zero_W%0d", t), 32'h0);
        end

        // Second message, interrupted by a mid-schedule reset, then rerun.
        for (int k = 0; k < 16; k++) msg[k] = 32'h0123_4567 * word_t'(k + 3) ^ {16'h0, 16'(k)};
        build_ref();
        for (int t = 0; t < 21; t++) begin
            step(1'b0, t, (t < 16) ? msg[t] : junk(t));
            expect_out($sformatf("msgb_pre_W%0d", t), ref_w[t]);
        end
        step(1'b1, 21, junk(21));
        step(1'b0, 22, junk(22));
        expect_out("msgb_discarded", 32'h0);
        for (int t = 0; t < 64; t++) begin
            step(1'b0, t, (t < 16) ? msg[t] : junk(t));
            expect_out($sformatf("msgb_W%0d", t), ref_w[t]);
        end

        // Let the monitor drain the last cycle.
        step(1'b0, 0, 32'h0);
        @(negedge CLK);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: the run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_w_mem

// File: doc/w_mem.md
W_MEM -- requirements
Module: w_mem

Interface
REQ-001 The block SHALL have no parameters; word width 32 and window depth 16 are fixed package constants.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 I  input  6  schedule index t (0..63) of the word currently presented or requested.
REQ-005 D_IN  input  32  message word W[t], meaningful only while I < 16.
REQ-006 D_OUT  output  32  schedule word W[t] for the current I.

Function
REQ-007 The block SHALL hold a 16-entry window of 32-bit registers w0..w15. For the current t, w0 = W[t-16] and w15 = W[t-1].
REQ-008 D_OUT SHALL be combinational from I, D_IN and the window, with zero-cycle latency.
REQ-009 While I < 16, D_OUT SHALL equal D_IN (pass-through).
REQ-010 While I >= 16, D_OUT SHALL equal sigma1(w14) + w9 + sigma0(w1) + w0, summed modulo 2^32 with carries discarded.
REQ-011 sigma0(x) SHALL be ROTR7(x) xor ROTR18(x) xor SHR3(x).
REQ-012 sigma1(x) SHALL be ROTR17(x) xor ROTR19(x) xor SHR10(x).
REQ-013 On every rising CLK with RST low, the window SHALL shift by one word: wk <= w(k+1) for k = 0..14, and w15 <= the current D_OUT.
REQ-014 The window SHALL shift every cycle unconditionally; there is no enable. The driver advances I by exactly 1 per cycle.
REQ-015 When I wraps from 63 to 0, the block SHALL return to pass-through with no special action. The window is refilled by the 16 new message words.
REQ-016 If I is non-sequential, D_OUT SHALL still follow REQ-009/REQ-010 using the current window contents; no error is flagged.
REQ-017 The internal words w0..w15 SHALL be individually named and visible to hierarchical probes for debug.

Reset
REQ-018 On a rising CLK with RST high, w0..w15 SHALL all clear to 0; reset takes priority over the shift.
REQ-019 During reset, D_OUT SHALL remain combinational per REQ-009/REQ-010 (0 for I >= 16 once the window is cleared).
REQ-020 Reset asserted mid-schedule SHALL discard the partial window. Correct output resumes only after 16 pass-through words at I = 0..15.

Structure
REQ-021 A shared package SHALL hold: the word width (32), the window depth (16), and the sigma0/sigma1 rotate and shift amounts (7/18/3, 17/19/10).
REQ-022 One sub-module, w_sigma (32-bit input, selectable sigma0/sigma1 output), is natural and SHALL be instantiated twice.
REQ-023 The adder SHALL be a 4-operand, 32-bit combinational sum in the top level; the output is not registered.

Verification
REQ-024 Pass-through: I = 0, D_IN = 0x48656C6C -> D_OUT = 0x48656C6C in the same cycle; at the next edge w15 = 0x48656C6C.
REQ-025 Message "Hello world!" with padding: W0..W3 = 0x48656C6C, 0x6F20776F, 0x726C6421, 0x80000000; W4..W14 = 0; W15 = 0x00000060. Sequencing I = 0..16 -> D_OUT at I = 16 = 0x17470237, which exercises the modulo-2^32 carry drop.
REQ-026 All-zero message words 0..15 -> D_OUT = 0 for every I = 16..63.
REQ-027 Reset: after a full 64-cycle run, assert RST for one cycle, then hold I = 16 -> w0..w15 = 0 and D_OUT = 0.
REQ-028 Wrap: run I = 0..63 and continue to I = 0 with D_IN = 0xDEADBEEF -> D_OUT = 0xDEADBEEF. The full 64-word schedule must match the SHA-256 reference model for the "Hello world!" block.
